// File: rtl/lru_backend_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master between NUM_REQ LRU cache backends.
// Optional build macro LRU_ARB_BEAT_CHECK_EN adds a beat counter and a sticky err_beat output.
module lru_backend_arbiter #(
    parameter int NUM_REQ            = 4,
    parameter int ADDR_WIDTH         = 48,
    parameter int CACHE_SIZE         = 2048,
    parameter int BACKEND_DATA_WIDTH = 512,
    localparam int OFFSET_BITS       = $clog2(CACHE_SIZE / 8),
    localparam int BEATS             = CACHE_SIZE / BACKEND_DATA_WIDTH,
    localparam int TAGS_WIDTH        = ADDR_WIDTH - OFFSET_BITS
) (
    input  logic                            clk,
    input  logic                            rstn,

    input  logic [NUM_REQ-1:0]              req_tag_valid,
    input  logic [NUM_REQ*TAGS_WIDTH-1:0]   req_tag,
    output logic [NUM_REQ-1:0]              req_tag_ready,

    output logic [NUM_REQ-1:0]              req_data_valid,
    output logic [BACKEND_DATA_WIDTH-1:0]   req_data,
    output logic                            req_data_last,
    input  logic [NUM_REQ-1:0]              req_data_ready,

    output logic                            m_arvalid,
    input  logic                            m_arready,
    output logic [ADDR_WIDTH-1:0]           m_araddr,
    output logic [7:0]                      m_arlen,
    output logic [2:0]                      m_arsize,
    output logic [1:0]                      m_arburst,
    output logic                            m_arid,

    input  logic                            m_rvalid,
    output logic                            m_rready,
    input  logic [BACKEND_DATA_WIDTH-1:0]   m_rdata,
    input  logic                            m_rlast,

    output logic                            busy
`ifdef LRU_ARB_BEAT_CHECK_EN
    ,
    output logic                            err_beat
`endif
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [GW-1:0]          grant_q;
    logic [GW-1:0]          rr_ptr_q;
    logic [GW-1:0]          pick_idx;
    logic [ADDR_WIDTH-1:0]  ar_addr_q;
    logic                   any_req;
    logic                   ar_hs;
    logic                   r_hs;
    logic [TAGS_WIDTH-1:0]  tag_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_tag
        assign tag_arr[i] = req_tag[i*TAGS_WIDTH +: TAGS_WIDTH];
    end

    // First set request strictly after ptr, wrapping; the last served requester ranks lowest.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                              input logic [GW-1:0]      ptr);
        logic [GW-1:0] sel;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && vld[idx]) begin
                sel   = GW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign any_req  = |req_tag_valid;
    assign pick_idx = rr_pick(req_tag_valid, rr_ptr_q);
    assign ar_hs    = m_arvalid && m_arready;
    assign r_hs     = m_rvalid && m_rready;

    assign m_araddr  = ar_addr_q;
    assign m_arlen   = 8'(BEATS - 1);
    assign m_arsize  = 3'($clog2(BACKEND_DATA_WIDTH / 8));
    assign m_arburst = 2'b01;
    assign m_arid    = 1'b0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= GW'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                grant_q <= pick_idx;
            end
            if (state_q == DATA && r_hs && m_rlast) begin
                rr_ptr_q <= grant_q;
            end
        end
    end

    // Address is datapath only; it is always rewritten before ADDR presents it.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && any_req) begin
            ar_addr_q <= {tag_arr[pick_idx], OFFSET_BITS'(0)};
        end
    end

    always_comb begin
        state_d        = state_q;
        m_arvalid      = 1'b0;
        m_rready       = 1'b0;
        req_tag_ready  = '0;
        req_data_valid = '0;
        req_data       = '0;
        req_data_last  = 1'b0;
        busy           = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (any_req) state_d = ADDR;
            end
            ADDR: begin
                m_arvalid              = 1'b1;
                req_tag_ready[grant_q] = m_arready;
                if (m_arready) state_d = DATA;
            end
            DATA: begin
                // Pure wires to the granted requester: no beat latency and no buffering.
                m_rready                = req_data_ready[grant_q];
                req_data_valid[grant_q] = m_rvalid;
                req_data                = m_rdata;
                req_data_last           = m_rlast;
                if (m_rvalid && req_data_ready[grant_q] && m_rlast) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef LRU_ARB_BEAT_CHECK_EN
    localparam int CW = $clog2(BEATS) + 1;

    logic [CW-1:0] beat_cnt_q;
    logic          err_beat_q;

    // Counter saturates so a runaway burst without rlast cannot wrap back to a legal count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt_q <= '0;
            err_beat_q <= 1'b0;
        end else begin
            if (ar_hs) begin
                beat_cnt_q <= '0;
            end else if (r_hs && beat_cnt_q != '1) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
            if (r_hs && (m_rlast != (beat_cnt_q == CW'(BEATS - 1)))) begin
                err_beat_q <= 1'b1;
            end
        end
    end

    assign err_beat = err_beat_q;
`endif

endmodule

// File: tb/tb_lru_backend_arbiter.sv
// Randomized bench for lru_backend_arbiter: requester and AXI slave models drive the DUT,
// a transaction-level reference predicts every output.
`timescale 1ns/1ps
module tb_lru_backend_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int ADDR_WIDTH = 48;
    localparam int DW         = 512;
    localparam int BEATS      = 4;
    localparam int TW         = 40;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic [NUM_REQ-1:0]     req_tag_valid;
    logic [NUM_REQ*TW-1:0]  req_tag;
    logic [NUM_REQ-1:0]     req_tag_ready;
    logic [NUM_REQ-1:0]     req_data_valid;
    logic [DW-1:0]          req_data;
    logic                   req_data_last;
    logic [NUM_REQ-1:0]     req_data_ready;
    logic                   m_arvalid;
    logic                   m_arready;
    logic [ADDR_WIDTH-1:0]  m_araddr;
    logic [7:0]             m_arlen;
    logic [2:0]             m_arsize;
    logic [1:0]             m_arburst;
    logic                   m_arid;
    logic                   m_rvalid;
    logic                   m_rready;
    logic [DW-1:0]          m_rdata;
    logic                   m_rlast;
    logic                   busy;
`ifdef LRU_ARB_BEAT_CHECK_EN
    logic                   err_beat;
`endif

    always #5 clk = ~clk;

    lru_backend_arbiter dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_tag_valid  (req_tag_valid),
        .req_tag        (req_tag),
        .req_tag_ready  (req_tag_ready),
        .req_data_valid (req_data_valid),
        .req_data       (req_data),
        .req_data_last  (req_data_last),
        .req_data_ready (req_data_ready),
        .m_arvalid      (m_arvalid),
        .m_arready      (m_arready),
        .m_araddr       (m_araddr),
        .m_arlen        (m_arlen),
        .m_arsize       (m_arsize),
        .m_arburst      (m_arburst),
        .m_arid         (m_arid),
        .m_rvalid       (m_rvalid),
        .m_rready       (m_rready),
        .m_rdata        (m_rdata),
        .m_rlast        (m_rlast),
        .busy           (busy)
`ifdef LRU_ARB_BEAT_CHECK_EN
        ,
        .err_beat       (err_beat)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference: phase 0 = no burst, 1 = address offered, 2 = line streaming.
    int                     phase;
    int                     owner;
    int                     last_owner;
    int                     rx_cnt;
    logic [ADDR_WIDTH-1:0]  exp_addr;
    logic [ADDR_WIDTH-1:0]  line_addr;
    logic [NUM_REQ-1:0]     hold;
    logic [TW-1:0]          tag_r [NUM_REQ];
    int                     dwait [NUM_REQ];
    int                     dlv_cnt [NUM_REQ];
    int                     last_at [NUM_REQ];
    int                     grant_log [$];
    logic [ADDR_WIDTH-1:0]  ar_log [$];

    // AXI slave model
    int                     s_left;
    int                     s_idx;
    logic [ADDR_WIDTH-1:0]  s_addr;

    int                     p_req, p_ar, p_rv, p_dr;
    logic [NUM_REQ-1:0]     req_mask;
    bit                     early_last;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input logic [ADDR_WIDTH-1:0] a, input int idx);
        return {8{a, 8'(idx), 8'hA5}};
    endfunction

    task automatic model_reset();
        phase      = 0;
        owner      = 0;
        last_owner = NUM_REQ - 1;
        rx_cnt     = 0;
        hold       = '0;
        s_left     = 0;
        s_idx      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dwait[i]   = 0;
            dlv_cnt[i] = 0;
            last_at[i] = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_tag_valid[i]       = hold[i];
            req_tag[i*TW +: TW]    = tag_r[i];
            req_data_ready[i]      = ($urandom_range(99) < p_dr);
        end
        m_arready = ($urandom_range(99) < p_ar);
        if (s_left > 0) begin
            m_rvalid = ($urandom_range(99) < p_rv);
            m_rdata  = beat_data(s_addr, s_idx);
            m_rlast  = (s_idx == BEATS - 1) || (early_last && s_idx == 2);
        end else begin
            m_rvalid = 1'b0;
            m_rdata  = {16{$urandom}};
            m_rlast  = 1'($urandom_range(1));
        end
    endtask

    task automatic check_and_model();
        logic [NUM_REQ-1:0] e_tr;
        logic [NUM_REQ-1:0] e_dv;
        logic               e_rr;
        int                 best;
        int                 pick;
        int                 d;
        e_tr = '0;
        e_dv = '0;
        e_rr = 1'b0;
        if (phase == 1 && m_arready) e_tr[owner] = 1'b1;
        if (phase == 2) begin
            e_rr = req_data_ready[owner];
            if (m_rvalid) e_dv[owner] = 1'b1;
        end
        chk("busy", busy, phase != 0);
        chk("arvalid", m_arvalid, phase == 1);
        if (phase == 1) chk("araddr", m_araddr, exp_addr);
        chk("tag_ready", req_tag_ready, e_tr);
        chk("rready", m_rready, e_rr);
        chk("data_valid", req_data_valid, e_dv);
        if (phase == 2) begin
            chk("data", req_data, m_rdata);
            chk("last", req_data_last, m_rlast);
        end

        // Observations taken straight from the DUT's handshakes.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_tag_ready[i] && req_tag_valid[i]) begin
                grant_log.push_back(i);
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (j != i && req_tag_valid[j]) begin
                        dwait[j]++;
                        chk("fair_wait", dwait[j] <= NUM_REQ - 1, 1'b1);
                    end
                end
                dwait[i] = 0;
            end
            if (req_data_valid[i] && req_data_ready[i]) begin
                dlv_cnt[i]++;
                if (req_data_last) last_at[i] = dlv_cnt[i];
            end
        end
        if (m_arvalid && m_arready) ar_log.push_back(m_araddr);

        case (phase)
            0: begin
                if (|hold) begin
                    best = NUM_REQ;
                    pick = 0;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        d = (i - last_owner - 1 + 2 * NUM_REQ) % NUM_REQ;
                        if (hold[i] && d < best) begin
                            best = d;
                            pick = i;
                        end
                    end
                    owner    = pick;
                    exp_addr = {tag_r[pick], 8'h00};
                    phase    = 1;
                end
            end
            1: begin
                if (m_arready) begin
                    hold[owner] = 1'b0;
                    line_addr   = exp_addr;
                    rx_cnt      = 0;
                    s_left      = BEATS;
                    s_idx       = 0;
                    s_addr      = m_araddr;
                    phase       = 2;
                end
            end
            default: begin
                if (m_rvalid && req_data_ready[owner]) begin
                    chk("rx_data", req_data, beat_data(line_addr, rx_cnt));
                    rx_cnt++;
                    s_idx++;
                    s_left--;
                    if (m_rlast) begin
                        phase      = 0;
                        last_owner = owner;
                        s_left     = 0;
                    end
                end
            end
        endcase

        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hold[i] && req_mask[i] && $urandom_range(99) < p_req) begin
                hold[i]  = 1'b1;
                tag_r[i] = {8'($urandom), $urandom};
            end
        end
    endtask

    task automatic cycle();
        drive();
        #2;
        check_and_model();
        @(posedge clk);
        #1;
    endtask

    task automatic set_knobs(input int rq, input int ar, input int rv, input int dr);
        p_req = rq;
        p_ar  = ar;
        p_rv  = rv;
        p_dr  = dr;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        drive();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic drain();
        int n;
        set_knobs(0, 100, 100, 100);
        n = 0;
        while ((phase != 0 || |hold) && n < 200) begin
            cycle();
            n++;
        end
        chk("drain_timeout", n < 200, 1'b1);
    endtask

    task automatic run_until_grants(input int k);
        int n;
        n = 0;
        while (grant_log.size() < k && n < 300) begin
            cycle();
            n++;
        end
        chk("grant_timeout", grant_log.size() >= k, 1'b1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NUM_REQ; i++) tag_r[i] = '0;
        req_mask   = '1;
        early_last = 1'b0;
        set_knobs(0, 100, 100, 100);
        rstn = 1'b0;
        model_reset();
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arvalid", m_arvalid, 1'b0);
        chk("rst_rready", m_rready, 1'b0);
        chk("rst_tag_ready", req_tag_ready, '0);
        chk("rst_data_valid", req_data_valid, '0);
        chk("rst_busy", busy, 1'b0);
        rstn = 1'b1;
        cycle();

        // Single request from requester 2 with a known tag.
        grant_log.delete();
        ar_log.delete();
        hold[2]  = 1'b1;
        tag_r[2] = 40'h12_3456_789A;
        repeat (8) cycle();
        chk("single_araddr", (ar_log.size() > 0) ? ar_log[0] : '0, 48'h1234_5678_9A00);
        chk("arlen", m_arlen, 8'd3);
        chk("arsize", m_arsize, 3'd6);
        chk("arburst", m_arburst, 2'b01);
        chk("arid", m_arid, 1'b0);
        chk("single_beats", dlv_cnt[2], 4);
        chk("single_last_pos", last_at[2], 4);
        chk("single_other_beats", dlv_cnt[0] + dlv_cnt[1] + dlv_cnt[3], 0);

        // All four requesting continuously from reset.
        do_reset();
        grant_log.delete();
        set_knobs(100, 100, 100, 100);
        hold = '1;
        for (int i = 0; i < NUM_REQ; i++) tag_r[i] = {8'($urandom), $urandom};
        run_until_grants(5);
        for (int k = 0; k < 5; k++) begin
            chk("rr_order", (grant_log.size() > k) ? grant_log[k] : -1, k % NUM_REQ);
        end
        drain();

        // AR stall then R backpressure.
        hold[1]  = 1'b1;
        tag_r[1] = {8'($urandom), $urandom};
        set_knobs(0, 0, 100, 100);
        repeat (7) cycle();
        set_knobs(0, 100, 100, 50);
        repeat (30) cycle();
        drain();

        // Random soak.
        set_knobs(30, 60, 70, 70);
        repeat (3000) cycle();
        drain();

        // Asynchronous reset in the middle of a line.
        hold[1]  = 1'b1;
        tag_r[1] = {8'($urandom), $urandom};
        n = 0;
        while (!(phase == 2 && rx_cnt == 2) && n < 100) begin
            cycle();
            n++;
        end
        chk("mid_data_timeout", n < 100, 1'b1);
        drive();
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_arvalid", m_arvalid, 1'b0);
        chk("arst_rready", m_rready, 1'b0);
        chk("arst_tag_ready", req_tag_ready, '0);
        chk("arst_data_valid", req_data_valid, '0);
        chk("arst_data", req_data, '0);
        chk("arst_last", req_data_last, 1'b0);
        chk("arst_busy", busy, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        grant_log.delete();
        hold = 4'b1101;
        for (int i = 0; i < NUM_REQ; i++) tag_r[i] = {8'($urandom), $urandom};
        run_until_grants(1);
        chk("post_reset_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        drain();

`ifdef LRU_ARB_BEAT_CHECK_EN
        chk("err_beat_clean", err_beat, 1'b0);
        early_last = 1'b1;
        hold[1]    = 1'b1;
        tag_r[1]   = {8'($urandom), $urandom};
        drain();
        early_last = 1'b0;
        chk("err_beat_set", err_beat, 1'b1);
        hold[3]  = 1'b1;
        tag_r[3] = {8'($urandom), $urandom};
        drain();
        chk("err_beat_sticky", err_beat, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lru_backend_arbiter.md
Name: lru_backend_arbiter

Overview:
Shares one AXI4 read master (address plus read-data channels) between NUM_REQ LRU cache instances, each presenting a backend tag stream and a line-fill data stream. Round-robin grant with one line-fill burst in flight at a time. R beats are routed only to the granted requester until RLAST. Sits between the per-cache backend streams and the backend AXI port of box_250mhz.

Parameters:
NUM_REQ, 4, number of cache requesters (2..8)
ADDR_WIDTH, 48, AXI byte address width
CACHE_SIZE, 2048, line size in bits; OFFSET_BITS = clog2(CACHE_SIZE/8) = 8
BACKEND_DATA_WIDTH, 512, RDATA width; BEATS = CACHE_SIZE/BACKEND_DATA_WIDTH = 4
TAGS_WIDTH, ADDR_WIDTH-OFFSET_BITS (40), line tag width

Ports:
clk  in  1  clock
rstn  in  1  reset
req_tag_valid  in  NUM_REQ  per-requester tag valid
req_tag  in  NUM_REQ*TAGS_WIDTH  packed tags, requester i at [i*TAGS_WIDTH +: TAGS_WIDTH]
req_tag_ready  out  NUM_REQ  tag accepted
req_data_valid  out  NUM_REQ  fill beat valid, one-hot or zero
req_data  out  BACKEND_DATA_WIDTH  fill beat, broadcast to all requesters
req_data_last  out  1  last beat of line
req_data_ready  in  NUM_REQ  per-requester beat ready
m_arvalid/m_arready  out/in  1  AXI AR handshake
m_araddr  out  ADDR_WIDTH  tag << OFFSET_BITS
m_arlen  out  8  constant BEATS-1
m_arsize  out  3  constant clog2(BACKEND_DATA_WIDTH/8)
m_arburst  out  2  constant 2'b01 (INCR)
m_arid  out  1  constant 0
m_rvalid/m_rready  in/out  1  AXI R handshake
m_rdata  in  BACKEND_DATA_WIDTH  read data
m_rlast  in  1  last beat
busy  out  1  state != IDLE

Behaviour:
- Reset: rstn is asynchronous, active-low. Asserting it forces the following from any state, including mid-burst:
  - state=IDLE, grant=0, rr_ptr=NUM_REQ-1
  - m_arvalid=0, m_rready=0, all req_* outputs 0, busy=0
  - Beats still in flight from the previous burst are not tracked; the system resets the backend together with this block.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any req_tag_valid is set, select the first set bit searching from rr_ptr+1, wrapping modulo NUM_REQ.
  - Register that index as grant and register the tag into ar_addr_q = {tag, OFFSET_BITS'b0}.
  - Next state ADDR. m_arvalid rises one cycle after req_tag_valid is first seen.
- ADDR:
  - m_arvalid=1; m_araddr is stable from ar_addr_q.
  - req_tag_ready[grant] = m_arready, combinational. The requester keeps its tag until the AR handshake completes.
  - On m_arvalid&&m_arready, go to DATA. Other requesters' tag_ready stays 0.
  - A req_tag_valid deassertion while in ADDR is ignored; the address is already registered. This is a requester protocol violation.
- DATA:
  - m_rready = req_data_ready[grant].
  - req_data_valid[grant] = m_rvalid; all other bits 0.
  - req_data = m_rdata, req_data_last = m_rlast. All paths are combinational, adding zero beat latency.
  - On m_rvalid&&m_rready&&m_rlast: rr_ptr<=grant, next state IDLE.
- Back-to-back: IDLE always lasts at least one cycle between bursts. The minimum burst cost is 1 (IDLE) + 1 (AR) + BEATS cycles.
- Fairness: a requester holding valid waits at most NUM_REQ-1 bursts.
- Simultaneous requests are resolved by rr_ptr only. A new valid arriving during DATA is considered only at the next IDLE.
- Backpressure: if the granted requester deasserts req_data_ready, m_rready drops in the same cycle. There is no buffering in this block.

Optional Feature:
LRU_ARB_BEAT_CHECK_EN:
- Defined:
  - Adds a beat counter, cleared on AR handshake and incremented on each R handshake.
  - Adds output err_beat (1 bit, sticky, cleared only by reset).
  - err_beat is set on an R handshake when m_rlast=1 with count != BEATS-1, or when m_rlast=0 with count == BEATS-1.
  - The burst still terminates on m_rlast in both cases.
- Undefined: no counter, and no err_beat port.

Test Plan:
- Single request: req 2 valid, tag 0x12_3456_789A, arready=1 -> m_arvalid one cycle later; m_araddr = 0x1234_5678_9A00; m_arlen=3; 4 beats delivered with only req_data_valid[2] set; last on beat 4; busy falls the cycle after.
- All four valid from reset (rr_ptr=3) -> grant order 0,1,2,3,0; each burst is 4 beats; no beat is seen on a non-granted requester.
- AR stall: m_arready low 5 cycles -> m_arvalid and m_araddr stable; req_tag_ready[grant] stays 0 until the handshake cycle.
- R backpressure: granted requester's ready low on beats 2-3 -> m_rready low in the same cycles; data order preserved; no beat duplicated or dropped.
- Reset mid-DATA after 2 beats -> all outputs 0 immediately (asynchronous); after release, a new request from req 0 is granted first.
- With LRU_ARB_BEAT_CHECK_EN: rlast on beat 3 -> err_beat=1 and stays set; FSM returns to IDLE; next normal burst completes with err_beat still 1.
